mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; sits directly downstream of the EX/MEM register.
- Consumes the EXMEM_* control and data outputs and drives a request/grant/response data-memory port.
- Stalls the pipeline while an access is outstanding, resolves branch/jump redirect, and registers writeback data for the WB mux.

Parameters:
XLEN, 64, datapath/address width
RD_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
EXMEM_Branch  in  1  branch instruction in MEM
EXMEM_Zero  in  1  ALU zero flag
EXMEM_Jal  in  1  jump-and-link
EXMEM_MemRead  in  1  load
EXMEM_MemWrite  in  1  store
EXMEM_MemtoReg  in  1  WB selects load data
EXMEM_RegWrite  in  1  register write enable
EM_addermuxselect  in  1  redirect target select
EXMEM_RD  in  RD_W  destination register
EXMEM_Result  in  XLEN  ALU result / memory byte address
EXMEM_WriteData  in  XLEN  store data
EXMEM_Adder2Out  in  XLEN  branch target
EXMEM_adder_out1  in  XLEN  PC+4 link value / alternate target
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  byte address
dmem_wdata  out  XLEN  store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  XLEN  load data
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
mem_pcsrc  out  1  redirect PC
mem_target  out  XLEN  redirect address
MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_Jal  out  1 each  registered WB controls
MEMWB_RD  out  RD_W  registered destination
MEMWB_ReadData, MEMWB_Result, MEMWB_LinkAddr  out  XLEN each  registered WB data

Behaviour:
- FSM states: IDLE, REQ, WAIT_R. Reset state is IDLE.
- access = EXMEM_MemRead | EXMEM_MemWrite. If both are set, treat the access as a store.
- dmem_req = access & (state IDLE or REQ). It is combinational.
- dmem_we, dmem_addr, dmem_wdata pass EXMEM_MemWrite, EXMEM_Result, EXMEM_WriteData straight through.
- FSM transitions:
  - IDLE/REQ, access, no gnt -> REQ.
  - Store with gnt -> IDLE; the access completes this cycle.
  - Load with gnt -> WAIT_R.
  - WAIT_R: stay until dmem_rvalid, then -> IDLE; the access completes this cycle.
- Timing and interface rules:
  - Minimum load latency is 2 cycles, i.e. 1 stall cycle.
  - A store with gnt in the first cycle causes no stall.
  - dmem_gnt while dmem_req=0 is ignored. dmem_rvalid outside WAIT_R is ignored.
- mem_stall = access & !complete, where complete = (store & gnt) | (WAIT_R & rvalid). Upstream registers hold their values while mem_stall=1.
- MEM/WB update on each clk edge:
  - mem_stall=1: insert a bubble. RegWrite, MemtoReg, Jal = 0; data registers hold.
  - Otherwise capture RegWrite, MemtoReg, Jal, RD, Result, LinkAddr (from adder_out1).
  - ReadData = dmem_rdata only on a completing load; otherwise it holds.
- Redirect:
  - mem_pcsrc = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal, combinational, gated off while mem_stall=1.
  - mem_target = EM_addermuxselect ? EXMEM_adder_out1 : EXMEM_Adder2Out.
- Reset (asynchronous, also mid-access):
  - FSM -> IDLE. All MEMWB_* outputs = 0.
  - dmem_req falls as soon as access or state allow. An in-flight response after reset is ignored.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined:
  - An access with EXMEM_Result[2:0] != 0 is suppressed: no dmem_req, no stall.
  - The instruction passes to MEM/WB with RegWrite forced 0.
  - Adds output mem_misalign (1 bit), high combinationally for that cycle.
- Undefined: no check is performed, the address goes out unmodified, and the mem_misalign port is absent.

Test Plan:
- Reset held low with dmem_gnt=1 -> dmem_req=0 and all MEMWB_* = 0; state remains IDLE after release.
- Load, Result=0x100, RD=5, gnt in cycle 0, rvalid+rdata=0xDEAD in cycle 2 -> mem_stall=1 for cycles 0-1; cycle 3 shows MEMWB_ReadData=0xDEAD, RD=5, RegWrite=1; a bubble is seen during the stall.
- Store, addr 0x08, data 0x55, gnt withheld 2 cycles -> dmem_req and mem_stall high 2 cycles, drop in the gnt cycle; MEMWB_RegWrite=0.
- Branch=1, Zero=1, addermuxselect=0, Adder2Out=0x40 -> mem_pcsrc=1, mem_target=0x40. Jal=1, adder_out1=0x24 -> MEMWB_LinkAddr=0x24, MEMWB_Jal=1.
- reset asserted while in WAIT_R, rvalid arrives during reset -> state IDLE, MEMWB_ReadData=0, no stall afterwards.
- MEM_MISALIGN_CHECK_EN defined: load with Result=0x103 -> mem_misalign=1, dmem_req=0, mem_stall=0, MEMWB_RegWrite=0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage and the data memory.
// master = MEM stage (issues requests), slave = memory (grants and returns load data).
interface mem_wb_stage_if #(
  parameter int XLEN = 64
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: drives the data-memory port, stalls upstream while an
// access is outstanding, resolves redirects. Optional macro MEM_MISALIGN_CHECK_EN suppresses misaligned accesses.
module mem_wb_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            EXMEM_Branch,
  input  logic            EXMEM_Zero,
  input  logic            EXMEM_Jal,
  input  logic            EXMEM_MemRead,
  input  logic            EXMEM_MemWrite,
  input  logic            EXMEM_MemtoReg,
  input  logic            EXMEM_RegWrite,
  input  logic            EM_addermuxselect,
  input  logic [RD_W-1:0] EXMEM_RD,
  input  logic [XLEN-1:0] EXMEM_Result,
  input  logic [XLEN-1:0] EXMEM_WriteData,
  input  logic [XLEN-1:0] EXMEM_Adder2Out,
  input  logic [XLEN-1:0] EXMEM_adder_out1,
  mem_wb_stage_if.master  dmem,
  output logic            mem_stall,
  output logic            mem_pcsrc,
  output logic [XLEN-1:0] mem_target,
  output logic            MEMWB_RegWrite,
  output logic            MEMWB_MemtoReg,
  output logic            MEMWB_Jal,
  output logic [RD_W-1:0] MEMWB_RD,
  output logic [XLEN-1:0] MEMWB_ReadData,
  output logic [XLEN-1:0] MEMWB_Result,
  output logic [XLEN-1:0] MEMWB_LinkAddr
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic            mem_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t          state_q;
  logic            access;
  logic            misalign;
  logic            acc_eff;
  logic            in_wait;
  logic            store_done;
  logic            load_done;
  logic            regwrite_q;
  logic            memtoreg_q;
  logic            jal_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] readdata_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] link_q;

  assign access = EXMEM_MemRead | EXMEM_MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign     = access & (|EXMEM_Result[2:0]);
  assign mem_misalign = misalign;
`else
  assign misalign = 1'b0;
`endif

  // Read+write together is a store, so MemWrite alone selects the access type.
  assign acc_eff    = access & ~misalign;
  assign in_wait    = (state_q == WAIT_R);
  assign store_done = dmem.dmem_req & EXMEM_MemWrite & dmem.dmem_gnt;
  assign load_done  = in_wait & dmem.dmem_rvalid;
  assign mem_stall  = acc_eff & ~(store_done | load_done);

  assign dmem.dmem_req   = acc_eff & ~in_wait;
  assign dmem.dmem_we    = EXMEM_MemWrite;
  assign dmem.dmem_addr  = EXMEM_Result;
  assign dmem.dmem_wdata = EXMEM_WriteData;

  assign mem_pcsrc  = ((EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal) & ~mem_stall;
  assign mem_target = EM_addermuxselect ? EXMEM_adder_out1 : EXMEM_Adder2Out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, REQ: begin
          if (!acc_eff)                state_q <= IDLE;
          else if (!dmem.dmem_gnt)     state_q <= REQ;
          else if (EXMEM_MemWrite)     state_q <= IDLE;
          else                         state_q <= WAIT_R;
        end
        WAIT_R: if (dmem.dmem_rvalid) state_q <= IDLE;
        default:                      state_q <= IDLE;
      endcase
    end
  end

  // MEM/WB boundary: a stall injects a bubble into WB while the data registers hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      jal_q      <= 1'b0;
      rd_q       <= '0;
      readdata_q <= '0;
      result_q   <= '0;
      link_q     <= '0;
    end else begin
      if (mem_stall) begin
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        jal_q      <= 1'b0;
      end else begin
        regwrite_q <= EXMEM_RegWrite & ~misalign;
        memtoreg_q <= EXMEM_MemtoReg;
        jal_q      <= EXMEM_Jal;
        rd_q       <= EXMEM_RD;
        result_q   <= EXMEM_Result;
        link_q     <= EXMEM_adder_out1;
      end
      if (load_done) readdata_q <= dmem.dmem_rdata;
    end
  end

  assign MEMWB_RegWrite = regwrite_q;
  assign MEMWB_MemtoReg = memtoreg_q;
  assign MEMWB_Jal      = jal_q;
  assign MEMWB_RD       = rd_q;
  assign MEMWB_ReadData = readdata_q;
  assign MEMWB_Result   = result_q;
  assign MEMWB_LinkAddr = link_q;

endmodule
